// File: rtl/dmem_ctrl.sv
// dmem_ctrl: turns core load/store requests into multi-cycle accesses on a
// synchronous SRAM, stalling the core while an access is in flight. A
// one-entry write-through buffer answers repeated loads with no stall.
//
// Core handshake: a request (req_rd/req_wr with req_addr/req_wdata) is
// accepted in IDLE. The core must hold the request stable while stall=1.
// The transfer completes in the first cycle with stall=0; rdata is valid
// from that cycle on.
module dmem_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic                buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;

  logic hit;
  logic start;

  // A store always goes to the SRAM (write-through); a load only on a miss.
  assign hit   = req_rd && buf_valid_q && (buf_addr_q == req_addr);
  assign start = req_wr || (req_rd && !hit);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      a_q         <= '0;
      d_q         <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      a_q         <= a_d;
      d_q         <= d_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    a_d         = a_q;
    d_d         = d_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Simultaneous load+store is treated as a store.
          op_wr_d = req_wr;
          a_d     = req_addr;
          d_d     = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          buf_data_d  = op_wr_q ? d_q : Q;
          buf_addr_d  = a_q;
          buf_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // The core retires at this edge; never start a new access here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Core stall and SRAM strobes decoded from the current state.
  always_comb begin
    stall = 1'b0;
    CEN   = 1'b1;
    WEN   = 1'b1;
    OEN   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        stall = rst_n && start;
      end
      ST_ACCESS: begin
        stall = rst_n;
        CEN   = 1'b0;
        WEN   = !op_wr_q;
        OEN   = op_wr_q;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign A         = a_q;
  assign D         = d_q;
  assign rdata     = buf_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed test of dmem_ctrl against a behavioural SRAM that
// samples on the falling clock edge. Main instance uses WAIT_CYC=2; a second
// instance covers WAIT_CYC=1.
module tb_dmem_ctrl;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic          clk;
  logic          rst_n;
  logic          req_rd, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] rdata;
  logic          stall, cen, wen, oen;
  logic [AW-1:0] a;
  logic [DW-1:0] d, q;
  logic [1:0]    dbg_state;

  logic          r1_rd, r1_wr;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic [DW-1:0] rdata1;
  logic          stall1, cen1, wen1, oen1;
  logic [AW-1:0] a1;
  logic [DW-1:0] d1, q1;
  logic [1:0]    dbg_state1;

  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];

  int n_cmp;
  int n_err;

  dmem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata), .stall(stall),
    .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .D(d), .Q(q), .dbg_state(dbg_state)
  );

  dmem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .req_rd(r1_rd), .req_wr(r1_wr),
    .req_addr(r1_addr), .req_wdata(r1_wdata), .rdata(rdata1), .stall(stall1),
    .CEN(cen1), .WEN(wen1), .OEN(oen1), .A(a1), .D(d1), .Q(q1), .dbg_state(dbg_state1)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAMs, sampling on the falling edge
  always @(negedge clk) begin
    if (!cen) begin
      if (!wen) mem[a] <= d;
      else if (!oen) q <= mem[a];
    end
  end

  always @(negedge clk) begin
    if (!cen1) begin
      if (!wen1) mem1[a1] <= d1;
      else if (!oen1) q1 <= mem1[a1];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current IDLE cycle, follow it to completion and
  // check strobes each cycle, the stall length, and the returned data.
  task automatic run_req(input string tag, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int exp_stall, input logic [DW-1:0] exp_rdata);
    int n;
    req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wd;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      if (n == 0) begin
        check_eq({tag, "_c0_cen"}, 32'(cen), 32'd1);
      end else begin
        check_eq({tag, "_acc_state"}, 32'(dbg_state), 32'(S_ACCESS));
        check_eq({tag, "_acc_cen"}, 32'(cen), 32'd0);
        check_eq({tag, "_acc_wen"}, 32'(wen), 32'(!wr));
        check_eq({tag, "_acc_oen"}, 32'(oen), 32'(wr));
        check_eq({tag, "_acc_a"}, 32'(a), 32'(addr));
        if (wr) check_eq({tag, "_acc_d"}, d, wd);
      end
      n++;
      step();
      #1;
    end
    check_eq({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
    check_eq({tag, "_end_cen"}, 32'(cen), 32'd1);
    check_eq({tag, "_end_wen"}, 32'(wen), 32'd1);
    check_eq({tag, "_end_oen"}, 32'(oen), 32'd1);
    check_eq({tag, "_end_state"}, 32'(dbg_state), (exp_stall > 0) ? 32'(S_DONE) : 32'(S_IDLE));
    step();
    req_rd = 1'b0;
    req_wr = 1'b0;
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]  = '0;
      mem1[i] = '0;
    end
    mem[0] = 32'd15;
    mem[1] = 32'd20;
    mem[3] = 32'd44;

    rst_n = 1'b0;
    req_rd = 1'b1; req_wr = 1'b1; req_addr = 7'd5; req_wdata = 32'd9;
    r1_rd = 1'b0; r1_wr = 1'b0; r1_addr = '0; r1_wdata = '0;

    // Reset with both requests asserted
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check_eq("rst_stall", 32'(stall), 32'd0);
      check_eq("rst_cen", 32'(cen), 32'd1);
      check_eq("rst_wen", 32'(wen), 32'd1);
      check_eq("rst_oen", 32'(oen), 32'd1);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_a", 32'(a), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));
    end
    rst_n = 1'b1;
    req_rd = 1'b0; req_wr = 1'b0;
    step();
    check_eq("post_rst_valid", 32'(dut.buf_valid_q), 32'd0);

    // Read miss, then immediate repeat hit
    run_req("rd0_miss", 1'b1, 1'b0, 7'd0, 32'd0, 3, 32'd15);
    run_req("rd0_hit", 1'b1, 1'b0, 7'd0, 32'd0, 0, 32'd15);

    // Store then load of the same address hits
    run_req("wr4", 1'b0, 1'b1, 7'd4, 32'd30, 3, 32'd30);
    check_eq("mem4", mem[4], 32'd30);
    run_req("rd4_hit", 1'b1, 1'b0, 7'd4, 32'd0, 0, 32'd30);

    // Miss on another address displaces the buffer
    run_req("rd1_miss", 1'b1, 1'b0, 7'd1, 32'd0, 3, 32'd20);
    check_eq("buf_addr1", 32'(dut.buf_addr_q), 32'd1);
    run_req("rd4_miss", 1'b1, 1'b0, 7'd4, 32'd0, 3, 32'd30);

    // Load and store together behave as a store
    run_req("rdwr2", 1'b1, 1'b1, 7'd2, 32'd7, 3, 32'd7);
    check_eq("mem2", mem[2], 32'd7);

    // Reset during a read access
    req_rd = 1'b1; req_wr = 1'b0; req_addr = 7'd3; req_wdata = '0;
    #1;
    check_eq("ra_c0_stall", 32'(stall), 32'd1);
    step();
    #1;
    check_eq("ra_acc_state", 32'(dbg_state), 32'(S_ACCESS));
    check_eq("ra_acc_cen", 32'(cen), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("ra_rst_stall", 32'(stall), 32'd0);
    step();
    check_eq("ra_cen", 32'(cen), 32'd1);
    check_eq("ra_state", 32'(dbg_state), 32'(S_IDLE));
    check_eq("ra_valid", 32'(dut.buf_valid_q), 32'd0);
    check_eq("ra_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    req_rd = 1'b0;
    step();
    run_req("rd0_after_rst", 1'b1, 1'b0, 7'd0, 32'd0, 3, 32'd15);

    // WAIT_CYC=1 instance: store then hit
    r1_wr = 1'b1; r1_addr = 7'd6; r1_wdata = 32'd99;
    #1;
    n = 0;
    while (stall1 === 1'b1 && n < 20) begin
      if (n == 1) begin
        check_eq("w1_acc_cen", 32'(cen1), 32'd0);
        check_eq("w1_acc_wen", 32'(wen1), 32'd0);
      end
      n++;
      step();
      #1;
    end
    check_eq("w1_stall_cycles", 32'(n), 32'd2);
    check_eq("w1_rdata", rdata1, 32'd99);
    check_eq("w1_state", 32'(dbg_state1), 32'(S_DONE));
    step();
    r1_wr = 1'b0;
    check_eq("w1_mem6", mem1[6], 32'd99);
    r1_rd = 1'b1;
    #1;
    check_eq("w1_hit_stall", 32'(stall1), 32'd0);
    check_eq("w1_hit_rdata", rdata1, 32'd99);
    step();
    r1_rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
